// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write port sequencer/arbiter.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } rf_arb_state_e;

  localparam int RF_REGS   = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester handshake plus register-file write port bundle.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = RF_DATA_W
);

  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0][RF_ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][DATA_W-1:0]    req_data;
  logic [N_REQ-1:0]                req_ready;
  logic                            rf_write_en;
  logic [RF_ADDR_W-1:0]            rf_write_ad;
  logic [DATA_W-1:0]               rf_data_in;
  logic                            init_done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_write_en, rf_write_ad, rf_data_in, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_write_en, rf_write_ad, rf_data_in, init_done
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Zero-sweeps x1..x31 after reset/clear, then round-robins the single register-file
// write port among N_REQ writeback requesters. All register-file inputs are registered.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  regfile_write_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [RF_ADDR_W-1:0] LAST_REG = RF_ADDR_W'(RF_REGS - 1);

  rf_arb_state_e        state_q, state_d;
  logic [RF_ADDR_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 we_q, we_d;
  logic [RF_ADDR_W-1:0] ad_q, ad_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 done_q, done_d;

  logic [N_REQ-1:0]     arb_req, gnt;
  logic [PTR_W-1:0]     g_idx;

  // Masking requests (not grants) keeps ready free of any addr/data dependence.
  assign arb_req = (state_q == ST_ARB && !clear) ? bus.req_valid : '0;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) g_idx = PTR_W'(i);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    ad_d     = ad_q;
    data_d   = data_q;
    done_d   = done_q;
    if (clear) begin
      state_d = ST_INIT;
      cnt_d   = RF_ADDR_W'(1);
      done_d  = 1'b0;
    end else if (state_q == ST_INIT) begin
      we_d   = 1'b1;
      ad_d   = cnt_q;
      data_d = '0;
      cnt_d  = cnt_q + RF_ADDR_W'(1);
      if (cnt_q == LAST_REG) begin
        state_d = ST_ARB;
        done_d  = 1'b1;
      end
    end else if (|gnt) begin
      // x0 transfers still complete the handshake and rotate priority; just no write.
      we_d     = |bus.req_addr[g_idx];
      ad_d     = bus.req_addr[g_idx];
      data_d   = bus.req_data[g_idx];
      rr_ptr_d = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= RF_ADDR_W'(1);
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      ad_q     <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      ad_q     <= ad_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.rf_write_en = we_q;
  assign bus.rf_write_ad = ad_q;
  assign bus.rf_data_in  = data_q;
  assign bus.init_done   = done_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the 32×32 register file's single write port. After reset, or on a `clear` request, it sweeps zeros into x1–x31. Afterwards it shares the write port round-robin among `N_REQ` writeback requesters over a valid/ready handshake. It sits between the writeback sources (ALU, load unit, debug) and the register file's `write_en`/`write_ad`/`data_in` inputs, and drives those inputs from registers.

## Interface
- `N_REQ`, default 3: number of requesters, range 2–8; index 0 is ALU writeback.
- `DATA_W`, default 32: register data width.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; the block is held in reset while low.
- `clear`  in  1  single-cycle pulse; restarts the zero sweep.
- `req_valid`  in  N_REQ  per-requester write request.
- `req_addr`  in  N_REQ×5  per-requester destination register.
- `req_data`  in  N_REQ×DATA_W  per-requester write data.
- `req_ready`  out  N_REQ  per-requester accept, one-hot or zero.
- `rf_write_en`  out  1  to register file `write_en`.
- `rf_write_ad`  out  5  to register file `write_ad`.
- `rf_data_in`  out  DATA_W  to register file `data_in`.
- `init_done`  out  1  high once the sweep completes; low during any sweep.

## Operation
- Two states: ST_INIT and ST_ARB.
- ST_INIT:
  - A 5-bit sweep counter `cnt` starts at 1.
  - Each cycle the block issues a write of 0 to register `cnt`, then increments `cnt`.
  - After issuing `cnt`=31, the next state is ST_ARB.
  - `req_ready` is all zero throughout ST_INIT.
- ST_ARB:
  - Grant goes to the first requester with `req_valid` high, searching from `rr_ptr` upward modulo N_REQ.
  - `req_ready[g]` is high for that requester only. The transfer completes when `req_valid[g] && req_ready[g]`.
  - On each transfer, `rr_ptr` ← (g+1) mod N_REQ.
  - When no requester is valid, `rr_ptr` holds.
- Handshake rules:
  - A requester keeps `valid`, `addr` and `data` stable until it sees `ready`.
  - `ready` never depends on the same requester's `addr` or `data`.
- x0 writes:
  - A transfer with `req_addr`=0 is accepted and consumes the grant, and `rr_ptr` advances.
  - `rf_write_en` stays 0 for that transfer.
- `clear` in ST_ARB:
  - The next state is ST_INIT with `cnt`=1, and `init_done` drops at the next edge.
  - No grant is given in the `clear` cycle (`req_ready` all zero).
  - `rr_ptr` holds its value.
- `clear` in ST_INIT: the sweep restarts at `cnt`=1.
- Reset values: state ST_INIT, `cnt`=1, `rr_ptr`=0. `rf_write_en`, `rf_write_ad`, `rf_data_in` and `init_done` are all 0. `req_ready` is all zero.
- Reset mid-sweep or mid-transfer: all state is discarded, and no write is issued on any edge while `reset` is low.

## Timing
- `rf_write_en`, `rf_write_ad` and `rf_data_in` are registered outputs.
- A transfer in cycle t produces the register-file write at the rising edge ending cycle t+1. The written value is readable asynchronously in cycle t+2.
- Sweep: the first edge after `reset` deasserts registers a write to x1. Writes x1..x31 occupy 31 consecutive cycles.
- `init_done` rises on the same edge that enters ST_ARB. `req_ready` can go high in that cycle.
- Throughput in ST_ARB: one transfer per cycle. Back-to-back grants to different requesters are allowed.
- A single valid requester is granted every cycle regardless of `rr_ptr`.
- `req_ready` is combinational from the state, `clear`, `req_valid` and `rr_ptr`.

## Structure
- Shared package `regfile_pkg`:
  - state enum `rf_arb_state_e` {ST_INIT, ST_ARB}
  - constants `RF_REGS`=32, `RF_ADDR_W`=5, `RF_DATA_W`=32
- Sub-module `rr_arbiter`: parameterised by N_REQ, with inputs `req` and `ptr` and a one-hot `gnt` output, purely combinational. The FSM, sweep counter, pointer update and output registers stay in the top.

## Test plan
- Reset release: hold `reset` low for 3 cycles, release → 31 writes of 0 to x1..x31 on consecutive edges. `init_done` rises after the x31 write. No `req_ready` during the sweep.
- Contention: all 3 requesters valid continuously with addr 5, 6, 7 and data 0xA, 0xB, 0xC → grants 0,1,2,0,1,2. Register-file writes are x5=0xA, x6=0xB, x7=0xC in that order, each one cycle after its grant.
- x0 drop: requester 1 writes addr 0, data 0xDEADBEEF → `req_ready[1]` is 1 and `rf_write_en` stays 0. The next grant goes to requester 2 when requesters 0 and 2 are both valid.
- Clear: pulse `clear` while requester 0 is valid → no grant that cycle. A 31-cycle sweep follows with `init_done` low throughout. Requester 0 is granted in the first ST_ARB cycle.
- Reset mid-sweep: assert `reset` at `cnt`=12 → outputs go to 0 immediately. After release the sweep restarts at x1.
- Back-pressure stability: requester 2 alone, valid for 1 cycle with addr 3 and data 0x1234 → one transfer, write x3=0x1234 at t+1. `rr_ptr` becomes 0.
